// File: rtl/spi_flash_arb_pkg.sv
// Shared types for the SPI flash arbiter: transaction FSM states and port indices.
package spi_flash_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    RD_DONE,
    WR_ISSUE,
    WR_BUSY
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/spi_flash_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter; the last-grant register moves only when a grant is accepted.
module rr_arbiter2
  import spi_flash_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       gnt_idx,
  output logic       gnt_valid
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_valid = |req;
    if (req == 2'b11) begin
      gnt_idx = ~last_q;
    end else begin
      gnt_idx = req[1];
    end
    last_d = (accept && gnt_valid) ? gnt_idx : last_q;
  end

  // Out of reset "port 1 went last", so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= PORT1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/spi_flash_arbiter.sv
// Shares one SPI flash controller between a fetch port and a DMA port; one transaction
// at a time, with a single counter timing both read timeouts and write busy periods.
module spi_flash_arbiter
  import spi_flash_arb_pkg::*;
#(
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 32,
  parameter int WR_BUSY_CYCLES = 65,
  parameter int RD_TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic              fl_read,
  output logic              fl_write,
  output logic [ADDR_W-1:0] fl_addr,
  output logic [DATA_W-1:0] fl_wdata,
  input  logic [DATA_W-1:0] fl_rdata,
  input  logic              fl_ready
);

  localparam int CNT_MAX = (RD_TIMEOUT > WR_BUSY_CYCLES) ? RD_TIMEOUT : WR_BUSY_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_BUSY_CYCLES - 1);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     gnt_q, gnt_d;
  logic                     fl_read_q, fl_read_d;
  logic                     fl_write_q, fl_write_d;
  logic [ADDR_W-1:0]        fl_addr_q, fl_addr_d;
  logic [DATA_W-1:0]        fl_wdata_q, fl_wdata_d;
  logic [1:0]               ack_q, ack_d;
  logic [1:0]               err_q, err_d;
  logic [1:0][DATA_W-1:0]   rdata_q, rdata_d;

  logic arb_idx;
  logic arb_valid;
  logic arb_accept;
  logic sel_we;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       ({req1, req0}),
    .accept    (arb_accept),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    fl_read_d  = 1'b0;
    fl_write_d = 1'b0;
    fl_addr_d  = fl_addr_q;
    fl_wdata_d = fl_wdata_q;
    ack_d      = '0;
    err_d      = '0;
    rdata_d    = rdata_q;
    arb_accept = 1'b0;
    sel_we     = (arb_idx == PORT1) ? we1 : we0;

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          arb_accept = 1'b1;
          gnt_d      = arb_idx;
          fl_addr_d  = (arb_idx == PORT1) ? addr1 : addr0;
          fl_wdata_d = (arb_idx == PORT1) ? wdata1 : wdata0;
          if (sel_we) begin
            state_d    = WR_ISSUE;
            fl_write_d = 1'b1;
          end else begin
            state_d   = RD_ISSUE;
            fl_read_d = 1'b1;
          end
        end
      end
      RD_ISSUE: begin
        state_d   = RD_WAIT;
        cnt_d     = '0;
        fl_read_d = 1'b1;
      end
      RD_WAIT: begin
        if (fl_ready) begin
          state_d        = RD_DONE;
          ack_d[gnt_q]   = 1'b1;
          rdata_d[gnt_q] = fl_rdata;
        end else if (cnt_q == RD_LAST) begin
          state_d        = RD_DONE;
          ack_d[gnt_q]   = 1'b1;
          err_d[gnt_q]   = 1'b1;
          rdata_d[gnt_q] = '0;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          fl_read_d = 1'b1;
        end
      end
      RD_DONE: begin
        state_d = IDLE;
      end
      WR_ISSUE: begin
        state_d      = WR_BUSY;
        cnt_d        = '0;
        ack_d[gnt_q] = (WR_LAST == '0);
      end
      WR_BUSY: begin
        // fl_ready stays high while the controller writes, so only the count matters.
        if (cnt_q == WR_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d        = cnt_q + 1'b1;
          ack_d[gnt_q] = (cnt_d == WR_LAST);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      gnt_q      <= PORT0;
      fl_read_q  <= 1'b0;
      fl_write_q <= 1'b0;
      fl_addr_q  <= '0;
      fl_wdata_q <= '0;
      ack_q      <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      fl_read_q  <= fl_read_d;
      fl_write_q <= fl_write_d;
      fl_addr_q  <= fl_addr_d;
      fl_wdata_q <= fl_wdata_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign ack0     = ack_q[PORT0];
  assign ack1     = ack_q[PORT1];
  assign err0     = err_q[PORT0];
  assign err1     = err_q[PORT1];
  assign rdata0   = rdata_q[PORT0];
  assign rdata1   = rdata_q[PORT1];
  assign fl_read  = fl_read_q;
  assign fl_write = fl_write_q;
  assign fl_addr  = fl_addr_q;
  assign fl_wdata = fl_wdata_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Scoreboard bench for spi_flash_arbiter: stimulus pushes expected acks, a monitor pops and checks them.
module tb_spi_flash_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0, req1;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [23:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        fl_read, fl_write;
  logic [23:0] fl_addr;
  logic [31:0] fl_wdata;
  logic [31:0] fl_rdata = '0;
  logic        fl_ready = 1'b1;

  spi_flash_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .fl_read(fl_read), .fl_write(fl_write), .fl_addr(fl_addr), .fl_wdata(fl_wdata),
    .fl_rdata(fl_rdata), .fl_ready(fl_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          port;
    bit          we;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    int          gcyc;
    int          cyc;
    int          rd_hi;
    int          wr_hi;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   iss0 = 0, iss1 = 0, done0 = 0, done1 = 0;
  int   mdl_n = 1;
  logic [31:0] mdl_data = '0;
  logic rst_smp = 1'b1;

  assign req0 = (iss0 != done0);
  assign req1 = (iss1 != done1);

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_smp <= rst;
  end

  // Requesters hold req until ack; a reset drops every outstanding request.
  always @(negedge clk) begin
    if (!rst) begin
      done0 = iss0;
      done1 = iss1;
    end else begin
      if (ack0) done0++;
      if (ack1) done1++;
    end
  end

  // Flash controller model: ready in the mdl_n-th RD_WAIT cycle (never when mdl_n is 0), high otherwise.
  int rd_hi_m = 0;
  always @(negedge clk) begin
    if (fl_read) rd_hi_m++;
    else         rd_hi_m = 0;
    if (fl_read) begin
      fl_ready = (mdl_n != 0) && (rd_hi_m == mdl_n + 1);
      fl_rdata = fl_ready ? mdl_data : 32'hA5A5_A5A5;
    end else begin
      fl_ready = 1'b1;
      fl_rdata = 32'h5A5A_5A5A;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: per-cycle invariants, reset-state checks, ack scoreboard.
  int  rd_hi = 0, wr_hi = 0;
  bit  stab_bad = 0, excl_bad = 0;
  always @(negedge clk) begin
    exp_t e;
    if ((fl_read && fl_write) || (ack0 && ack1)) excl_bad = 1;
    if (!rst_smp) begin
      chk("reset_outputs", {ack0, ack1, err0, err1, fl_read, fl_write,
                            rdata0 != 0, rdata1 != 0, fl_addr != 0, fl_wdata != 0}, 64'd0);
      rd_hi = 0; wr_hi = 0; stab_bad = 0; excl_bad = 0;
    end else begin
      if (fl_read)  rd_hi++;
      if (fl_write) wr_hi++;
      if (q.size() > 0 && cyc > q[0].gcyc && cyc <= q[0].cyc) begin
        if (fl_addr !== q[0].addr) stab_bad = 1;
        if (q[0].we && fl_wdata !== q[0].wdata) stab_bad = 1;
      end
      if (ack0 || ack1) begin
        if (q.size() == 0) begin
          chk("unexpected_ack", {ack0, ack1}, 64'd0);
        end else begin
          e = q.pop_front();
          $display("[TB] ack port%0d cyc %0d rdata0 %08h rdata1 %08h err %0d%0d", ack1, cyc, rdata0, rdata1, err0, err1);
          chk("ack_port",   {ack1, ack0}, e.port ? 64'd2 : 64'd1);
          chk("ack_cycle",  cyc, e.cyc);
          chk("ack_err",    e.port ? err1 : err0, e.err);
          if (!e.we) chk("ack_rdata", e.port ? rdata1 : rdata0, e.rdata);
          chk("read_strobe_cycles",  rd_hi, e.rd_hi);
          chk("write_strobe_cycles", wr_hi, e.wr_hi);
          chk("addr_data_stable", stab_bad, 0);
          chk("exclusivity", excl_bad, 0);
        end
        rd_hi = 0; wr_hi = 0; stab_bad = 0; excl_bad = 0;
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
        e = q.pop_front();
        chk("ack_missing", cyc, e.cyc);
      end
    end
  end

  // n is the RD_WAIT cycle count for reads; writes take a fixed 66 cycles.
  task automatic push(input bit p, input bit we, input logic [23:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input bit er, input int g, input int n);
    exp_t e;
    e.port = p; e.we = we; e.addr = a; e.wdata = wd; e.rdata = rd; e.err = er; e.gcyc = g;
    e.cyc   = we ? g + 66 : g + 2 + n;
    e.rd_hi = we ? 0 : 1 + n;
    e.wr_hi = we ? 1 : 0;
    q.push_back(e);
  endtask

  task automatic set_port(input bit p, input bit we, input logic [23:0] a, input logic [31:0] wd);
    if (p) begin we1 = we; addr1 = a; wdata1 = wd; end
    else   begin we0 = we; addr0 = a; wdata0 = wd; end
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((q.size() != 0 || iss0 != done0 || iss1 != done1) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) begin
      $display("FAIL wait_idle: %0d transactions still queued after %0d cycles, expected 0", q.size(), k);
      $fatal(1, "bench stalled");
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int g;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // single read, port 0, ready in the 66th wait cycle
    mdl_n = 66; mdl_data = 32'hDEAD_BEEF;
    set_port(0, 0, 24'h000100, 32'h0);
    push(0, 0, 24'h000100, 32'h0, 32'hDEAD_BEEF, 0, cyc, 66);
    iss0++;
    wait_idle();

    // single write, port 1
    set_port(1, 1, 24'h000200, 32'h1234_5678);
    push(1, 1, 24'h000200, 32'h1234_5678, 32'h0, 0, cyc, 0);
    iss1++;
    wait_idle();

    // both ports request two reads each: grants alternate 0,1,0,1 with 5-cycle spacing
    mdl_n = 2; mdl_data = 32'h0BAD_F00D;
    set_port(0, 0, 24'h000300, 32'h0);
    set_port(1, 0, 24'h000400, 32'h0);
    g = cyc;
    push(0, 0, 24'h000300, 32'h0, 32'h0BAD_F00D, 0, g,      2);
    push(1, 0, 24'h000400, 32'h0, 32'h0BAD_F00D, 0, g + 5,  2);
    push(0, 0, 24'h000300, 32'h0, 32'h0BAD_F00D, 0, g + 10, 2);
    push(1, 0, 24'h000400, 32'h0, 32'h0BAD_F00D, 0, g + 15, 2);
    iss0 += 2; iss1 += 2;
    wait_idle();

    // read timeout: ready never rises
    mdl_n = 0;
    set_port(0, 0, 24'h000500, 32'h0);
    push(0, 0, 24'h000500, 32'h0, 32'h0, 1, cyc, 255);
    iss0++;
    wait_idle();

    // normal read right after the timeout
    mdl_n = 3; mdl_data = 32'hCAFE_F00D;
    set_port(0, 0, 24'h000600, 32'h0);
    push(0, 0, 24'h000600, 32'h0, 32'hCAFE_F00D, 0, cyc, 3);
    iss0++;
    wait_idle();

    // reset at write-busy count 30: no ack expected
    set_port(0, 1, 24'h000700, 32'hAAAA_5555);
    g = cyc;
    iss0++;
    while (cyc < g + 32) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);

    // after reset port 0 is preferred on a tie
    mdl_n = 4; mdl_data = 32'h5A5A_C3C3;
    set_port(0, 0, 24'h000800, 32'h0);
    set_port(1, 0, 24'h000900, 32'h0);
    g = cyc;
    push(0, 0, 24'h000800, 32'h0, 32'h5A5A_C3C3, 0, g,     4);
    push(1, 0, 24'h000900, 32'h0, 32'h5A5A_C3C3, 0, g + 7, 4);
    iss0++; iss1++;
    wait_idle();

    // port 1 read arrives while port 0 write is busy
    set_port(0, 1, 24'h000A00, 32'h1357_9BDF);
    g = cyc;
    push(0, 1, 24'h000A00, 32'h1357_9BDF, 32'h0, 0, g, 0);
    iss0++;
    repeat (10) @(negedge clk);
    mdl_n = 5; mdl_data = 32'h600D_CAFE;
    set_port(1, 0, 24'h000B00, 32'h0);
    push(1, 0, 24'h000B00, 32'h0, 32'h600D_CAFE, 0, g + 67, 5);
    iss1++;
    wait_idle();

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_flash_arbiter.md
Name: spi_flash_arbiter

Overview:
- Shares the single off-chip SPI flash controller between two requesters: port 0 (instruction fetch) and port 1 (DMA/data).
- Round-robin arbitration; drives the controller's level-sensitive read/write strobes; tracks transfer completion from its ready output and a fixed write-busy count.
- Returns a one-cycle ack per request, with read data and an error flag.
- Sits between the bus-side masters and the flash controller.

Parameters:
ADDR_W, 24, flash byte address width
DATA_W, 32, data word width
WR_BUSY_CYCLES, 65, cycles after write issue until the controller is back in IDLE (1 WRITE1 + 64 WRITE2)
RD_TIMEOUT, 255, max cycles waiting for read completion before error

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
req0  in  1  port 0 request, held until ack0
we0  in  1  port 0 write enable (1 = write)
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
ack0  out  1  port 0 completion pulse
rdata0  out  DATA_W  port 0 read data, valid with ack0
err0  out  1  port 0 timeout error, valid with ack0
req1/we1/addr1/wdata1/ack1/rdata1/err1  as port 0, for port 1
fl_read  out  1  controller read strobe (level)
fl_write  out  1  controller write strobe (level)
fl_addr  out  ADDR_W  address to controller
fl_wdata  out  DATA_W  write data to controller
fl_rdata  in  DATA_W  controller read data
fl_ready  in  1  controller ready

Behaviour:
- Reset (rst=0 at posedge): state IDLE; all outputs 0; rr pointer = port 0 preferred; counters 0. Mid-operation reset aborts the transfer silently with no ack.
- Arbitration, in IDLE only:
  - Only one req high: grant it.
  - Both high: grant the port not granted last.
  - Grant is latched for the whole transaction.
  - Requests arriving mid-transaction wait.
- Latching at grant: fl_addr/fl_wdata registered from the granted port and held stable until return to IDLE.
- States:
  - IDLE: if any req, latch grant, go RD_ISSUE (we=0) or WR_ISSUE (we=1).
  - RD_ISSUE: fl_read=1 for 1 cycle → RD_WAIT.
  - RD_WAIT:
    - fl_read=1; timeout counter increments.
    - fl_ready=1 → capture fl_rdata, go RD_DONE.
    - Counter reaches RD_TIMEOUT-1 → go RD_DONE with err=1, rdata=0.
  - RD_DONE: fl_read=0 (lets the controller leave READ3); ack/rdata/err of the granted port driven for exactly this cycle → IDLE.
  - WR_ISSUE: fl_write=1 for exactly 1 cycle → WR_BUSY (the controller loads data on the following cycle).
  - WR_BUSY:
    - fl_write=0; busy counter counts 0..WR_BUSY_CYCLES-1.
    - fl_ready is ignored, since it stays high during writes.
    - ack pulses on the cycle the counter equals WR_BUSY_CYCLES-1 → IDLE.
- Latency, from grant cycle (IDLE with req) to ack:
  - Read: 2 + N cycles, where N = cycles until fl_ready is seen high in RD_WAIT.
  - Write: 1 + WR_BUSY_CYCLES cycles.
- Back-to-back: IDLE may issue on the cycle after RD_DONE or WR_BUSY end; the controller is guaranteed to be in IDLE then.
- Output exclusivity:
  - fl_read and fl_write never high together.
  - ack0 and ack1 never high together.
  - rdata of the non-granted port holds its last value.
- A port whose req drops before ack still completes; the ack is still generated.
- Requesters are held off (no ack) while another transaction is active.

Decomposition:
- Package spi_flash_arb_pkg:
  - State encoding constants: IDLE, RD_ISSUE, RD_WAIT, RD_DONE, WR_ISSUE, WR_BUSY.
  - Port index constants.
- Sub-module rr_arbiter2: 2-input round-robin grant with last-grant register, updated only on grant accept.
- The counter is shared between read timeout and write busy.

Test Plan:
- Single read, port 0, addr 0x000100; model returns ready after 66 cycles with 0xDEADBEEF → fl_read high 67 cycles, ack0 at cycle 68 after grant, rdata0=0xDEADBEEF, err0=0.
- Single write, port 1, addr 0x000200, wdata 0x12345678 → fl_write high exactly 1 cycle, fl_wdata stable throughout, ack1 exactly 66 cycles after grant, no ack0.
- req0 and req1 both held continuously, all reads → grants alternate 0,1,0,1; no port gets two consecutive acks; one idle cycle between transactions.
- Read timeout: model never raises ready → ack0 with err0=1 and rdata0=0 exactly 2+255 cycles after grant; next request is served normally.
- Reset (rst=0) asserted during WR_BUSY at count 30 → next cycle all outputs 0, no ack; a new read after reset completes correctly.
- Read from port 1 issued while port 0 write is busy → ack1 only after ack0 plus the read latency; fl_addr switches only in IDLE.
